// File: rtl/bsg_rocket_pkg.sv
// Shared widths for the rocket host tunnel.
//   bsg_tun_dmx_width_p : width of one tunnel-demux beat in bits
package bsg_rocket_pkg;

    localparam int bsg_tun_dmx_width_p = 32;

endpackage

// File: rtl/bsg_host_arb.sv
// bsg_host_arb
//   Round-robin, packet-locking arbiter that shares the host-out channel among
//   els_p tunnel-demux requesters. A grant is held from the first presented beat
//   until the owner's last beat is accepted. All data/handshake paths are
//   combinational; only the state, round-robin pointer and owner are registered.
//
// Ports
//   clk_i        : clock
//   reset_i      : synchronous, active-high reset
//   v_i          : per-requester beat valid             [els_p]
//   data_i       : per-requester beat data, r at [r*width_p +: width_p]
//   last_i       : per-requester last-beat flag         [els_p]
//   yumi_o       : per-requester beat consumed (one-hot or zero)
//   host_valid_o : host-out beat valid
//   host_data_o  : host-out beat data
//   host_last_o  : host-out last-beat flag
//   host_tag_o   : index of the granted requester
//   host_ready_i : host side accepts a beat
//
// state  | meaning
// IDLE   | no packet in flight; grant by round-robin search from ptr_q
// LOCKED | packet (or stalled beat) in flight; only owner_q may send
module bsg_host_arb
    import bsg_rocket_pkg::*;
#(
    parameter int els_p   = 4,
    parameter int width_p = bsg_tun_dmx_width_p,
    localparam int tag_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [els_p-1:0]           v_i,
    input  logic [els_p*width_p-1:0]   data_i,
    input  logic [els_p-1:0]           last_i,
    output logic [els_p-1:0]           yumi_o,
    output logic                       host_valid_o,
    output logic [width_p-1:0]         host_data_o,
    output logic                       host_last_o,
    output logic [tag_width_lp-1:0]    host_tag_o,
    input  logic                       host_ready_i
);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                  state_q, state_d;
    logic [tag_width_lp-1:0] ptr_q, ptr_d;
    logic [tag_width_lp-1:0] owner_q, owner_d;

    logic [tag_width_lp-1:0] pick;
    logic                    found;
    logic [tag_width_lp:0]   cand;
    logic [tag_width_lp-1:0] grant;
    logic                    valid_raw;
    logic                    accept;

    // Increment with wrap at els_p so non-power-of-2 counts never overrun.
    function automatic logic [tag_width_lp-1:0] wrap_inc(input logic [tag_width_lp-1:0] x);
        return (x == tag_width_lp'(els_p - 1)) ? '0 : x + 1'b1;
    endfunction

    // Round-robin search starting at ptr_q; falls back to ptr_q when nobody is
    // valid so the idle outputs reflect the pointer's requester.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        cand  = '0;
        for (int i = 0; i < els_p; i++) begin
            cand = {1'b0, ptr_q} + (tag_width_lp + 1)'(i);
            if (cand >= (tag_width_lp + 1)'(els_p)) begin
                cand = cand - (tag_width_lp + 1)'(els_p);
            end
            if (!found && v_i[cand[tag_width_lp-1:0]]) begin
                found = 1'b1;
                pick  = cand[tag_width_lp-1:0];
            end
        end
    end

    assign grant        = (state_q == LOCKED) ? owner_q : pick;
    assign valid_raw    = (state_q == LOCKED) ? v_i[owner_q] : found;
    assign host_valid_o = valid_raw & ~reset_i;
    assign accept       = host_valid_o & host_ready_i;
    assign host_tag_o   = grant;

    always_comb begin
        host_data_o = '0;
        host_last_o = 1'b0;
        yumi_o      = '0;
        for (int r = 0; r < els_p; r++) begin
            if (grant == tag_width_lp'(r)) begin
                host_data_o = data_i[r*width_p +: width_p];
                host_last_o = last_i[r];
                yumi_o[r]   = accept;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                // A stalled beat or the head of a multi-beat packet pins the grant.
                if (host_valid_o && (!host_ready_i || !host_last_o)) begin
                    state_d = LOCKED;
                    owner_d = grant;
                end else if (accept) begin
                    ptr_d = wrap_inc(grant);
                end
            end
            LOCKED: begin
                if (accept && host_last_o) begin
                    state_d = IDLE;
                    ptr_d   = wrap_inc(owner_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: doc/bsg_host_arb.md
# bsg_host_arb

Round-robin, packet-locking arbiter that shares the single host-out channel between `els_p` tunnel-demux requesters. Each requester presents beats on a valid/yumi interface tagged with a last-beat flag. The arbiter grants one requester at a time and holds the grant until that requester's last beat is accepted. It sits between the per-channel `bsg_tun_dmx_t` sources and the `bsg_host` host-out port (`host_valid_o`/`host_ready_i`).

## Interface
Parameters:
- `els_p`, default 4: number of requesters; legal range 2..16.
- `width_p`, default `bsg_tun_dmx_width_p` (from `bsg_rocket_pkg`): beat width in bits.
- `tag_width_lp`, derived: `$clog2(els_p)`, minimum 1.

Ports:
- `clk_i`, in, 1: the single clock.
- `reset_i`, in, 1: synchronous, active-high reset.
- `v_i`, in, `els_p`: per-requester beat valid.
- `data_i`, in, `els_p*width_p`: requester r occupies bits [r*width_p +: width_p].
- `last_i`, in, `els_p`: beat is the final beat of its packet.
- `yumi_o`, out, `els_p`: beat of requester r was consumed this cycle.
- `host_valid_o`, out, 1: host-out beat valid.
- `host_data_o`, out, `width_p`: data of the granted requester.
- `host_last_o`, out, 1: `last_i` of the granted requester.
- `host_tag_o`, out, `tag_width_lp`: index of the granted requester.
- `host_ready_i`, in, 1: host side accepts a beat.

## Operation
- State: `state_r` in {IDLE, LOCKED}, `ptr_r` (round-robin start index), `owner_r` (locked requester).
- IDLE:
  - Grant goes to the first r with `v_i[r]`, searching `ptr_r`, `ptr_r+1`, … modulo `els_p`.
  - If no request is valid, `host_valid_o` is 0.
- LOCKED: only `owner_r` may drive the output. `host_valid_o = v_i[owner_r]`. All other requesters see `yumi_o = 0`.
- Output path:
  - `host_data_o`, `host_last_o` and `host_tag_o` mux from the granted index.
  - When `host_valid_o` is 0, the outputs hold `data_i` and `last_i` of index `ptr_r` (IDLE) or `owner_r` (LOCKED), and `host_tag_o` equals that index.
- Handshake:
  - Accept is `host_valid_o & host_ready_i`.
  - `yumi_o[g] = accept` for the granted index g; every other bit of `yumi_o` is 0. The `yumi_o` vector is one-hot or zero.
- Transitions:
  - IDLE → LOCKED (`owner_r <= g`) when `host_valid_o & ~host_ready_i`. This is a stalled beat, and the grant must not change while valid is presented.
  - IDLE → LOCKED (`owner_r <= g`) when accept and `~host_last_o`. This is the first beat of a multi-beat packet.
  - IDLE stays IDLE on accept with `host_last_o`, and sets `ptr_r <= g+1` (wrap at `els_p`).
  - LOCKED → IDLE on accept with `host_last_o`, and sets `ptr_r <= owner_r+1` (wrap).
  - LOCKED stays LOCKED otherwise, including while `v_i[owner_r]` is 0. This gap in the packet is legal, and the lock is held indefinitely.
- Requesters must keep `v_i` and data stable once asserted until yumi. The arbiter relies on this and does not check it.

## Timing
- Zero-latency combinational path: `v_i`/`data_i` → `host_*_o`, and `host_ready_i` → `yumi_o`. The only registers are `state_r`, `ptr_r` and `owner_r`.
- Throughput is one beat per cycle. A new packet from a different requester can be granted in the cycle after the previous last beat is accepted. There are no bubble cycles.
- Reset (synchronous, while `reset_i` is high):
  - `state_r <= IDLE`, `ptr_r <= 0`, `owner_r <= 0`.
  - `host_valid_o` and all `yumi_o` bits are forced to 0 during any cycle where `reset_i` is 1.
- Reset asserted mid-packet aborts the lock. After reset the arbiter starts in IDLE with priority at requester 0, and partially sent packets are not resumed.
- Index wrap: `ptr_r` equal to `els_p-1`, plus 1, wraps to 0. For `els_p` not a power of 2, the index never reaches values ≥ `els_p`.
- Simultaneous events: all requesters valid in IDLE resolves to `ptr_r`'s requester. A single-beat packet (`last_i = 1` on the first beat) never enters LOCKED if it is accepted the same cycle.
- Priority rotation is fair. Under continuous requests from all requesters, each requester is granted once per `els_p` packets.

## Test plan
- **Reset.** Hold `reset_i` 3 cycles with `v_i = 4'b1111` and `host_ready_i = 1` → `host_valid_o = 0` and `yumi_o = 0` throughout. On the first post-reset cycle, `host_tag_o = 0`.
- **Round-robin, single-beat.** `els_p = 4`, `v_i = 4'b1111`, `last_i = 4'b1111`, `host_ready_i = 1` for 8 cycles → `host_tag_o` sequence 0,1,2,3,0,1,2,3; `yumi_o` sequence 0001, 0010, 0100, 1000, repeating.
- **Packet lock.** Requester 1 sends 3 beats (`last_i` on beat 3) while requester 2 is continuously valid → tags 1,1,1,2; `yumi_o[2]` stays 0 until the cycle after requester 1's last beat.
- **Backpressure.** Requester 0 is valid, `host_ready_i = 0` for 4 cycles, and requester 3 raises `v_i` in cycle 2 → tag stays 0 and `host_data_o` is stable for all 4 cycles; accept happens on the first cycle with `host_ready_i = 1`, and requester 3 is granted next.
- **Lock gap.** Requester 2 sends beat 1 (not last), then drops `v_i[2]` for 5 cycles while requester 0 is valid → `host_valid_o = 0` and `yumi_o[0] = 0` during the gap; requester 2 resumes, finishes, then requester 0 is granted.
- **Wrap and mid-packet reset.** `ptr_r = 3` via a grant to requester 3 → the next grant searches from 0. Assert reset after beat 2 of a 4-beat packet from requester 3 → after reset, IDLE with requester 0 winning if valid.
